// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - command, response and APB bus bundle for apb_master_bridge
//
// Purpose: groups the command stream, response stream and APB signals of the bridge.
// Ports (master modport = bridge side):
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata   command stream into the bridge
//   rsp_valid/rsp_ready/rsp_rdata/rsp_slverr/rsp_timeout response stream out of the bridge
//   paddr/prwd/pwdata/psel/penable                     APB request driven by the bridge
//   prdata/pslverr/pready                              APB completion driven by the slave
// The slave modport is the environment view (command source, response sink, APB slave).
interface apb_master_bridge_if #(
    parameter int PADDR_WIDTH  = 32,
    parameter int PWDATA_WIDTH = 8,
    parameter int PRDATA_WIDTH = PWDATA_WIDTH
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [PADDR_WIDTH-1:0]  cmd_addr;
    logic [PWDATA_WIDTH-1:0] cmd_wdata;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [PRDATA_WIDTH-1:0] rsp_rdata;
    logic                    rsp_slverr;
    logic                    rsp_timeout;

    logic [PADDR_WIDTH-1:0]  paddr;
    logic                    prwd;
    logic [PWDATA_WIDTH-1:0] pwdata;
    logic                    psel;
    logic                    penable;
    logic [PRDATA_WIDTH-1:0] prdata;
    logic                    pslverr;
    logic                    pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  prdata, pslverr, pready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output paddr, prwd, pwdata, psel, penable
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output prdata, pslverr, pready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  paddr, prwd, pwdata, psel, penable
    );
endinterface

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB initiator driven by a valid/ready command stream
//
// Purpose: accepts one command, runs one APB transfer (SETUP then ACCESS), returns one
// response, and aborts with a timeout response if pready stays low too long.
// Ports:
//   pclock  APB clock, rising edge
//   preset  asynchronous active-high reset
//   bus     apb_master_bridge_if.master (command in, response out, APB master signals)
// Parameters:
//   PADDR_WIDTH, PWDATA_WIDTH, PRDATA_WIDTH  bus widths
//   TIMEOUT_CYCLES  ACCESS cycles with pready low before abort; 0 disables the timeout
module apb_master_bridge #(
    parameter int PADDR_WIDTH    = 32,
    parameter int PWDATA_WIDTH   = 8,
    parameter int PRDATA_WIDTH   = PWDATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 pclock,
    input  logic                 preset,
    apb_master_bridge_if.master  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // Sized to hold TIMEOUT_CYCLES; the abort fires at TIMEOUT_CYCLES-1 so it never wraps.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [PRDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_slverr_q, rsp_slverr_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [PADDR_WIDTH-1:0]  paddr_q, paddr_d;
    logic                    prwd_q, prwd_d;
    logic [PWDATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;
        paddr_d       = paddr_q;
        prwd_d        = prwd_q;
        pwdata_d      = pwdata_q;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready_q gates acceptance so the cycle right after reset release
                // (cmd_ready still 0) cannot swallow a command.
                if (bus.cmd_valid && cmd_ready_q) begin
                    paddr_d  = bus.cmd_addr;
                    prwd_d   = bus.cmd_write;
                    pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready is tested first so a completion on the threshold cycle wins.
                if (bus.pready) begin
                    rsp_rdata_d   = prwd_q ? '0 : bus.prdata;
                    rsp_slverr_d  = bus.pslverr;
                    rsp_timeout_d = 1'b0;
                    cnt_d         = '0;
                    state_d       = ST_RESP;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    rsp_rdata_d   = '0;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = ST_RESP;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake/strobe outputs are registered copies of the next state.
        cmd_ready_d = (state_d == ST_IDLE);
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge pclock or posedge preset) begin
        if (preset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            paddr_q       <= '0;
            prwd_q        <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
            paddr_q       <= paddr_d;
            prwd_q        <= prwd_d;
            pwdata_q      <= pwdata_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_slverr  = rsp_slverr_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.paddr       = paddr_q;
    assign bus.prwd        = prwd_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - scoreboard bench for apb_master_bridge
module tb_apb_master_bridge;
    localparam int AW = 32;
    localparam int WW = 8;
    localparam int RW = 8;
    localparam int TO = 4;

    typedef struct {
        logic [RW-1:0] rdata;
        logic          slverr;
        logic          timeout;
        int unsigned   rsp_edge;
    } exp_t;

    typedef struct {
        int            w;
        logic          err;
        logic          write;
        logic [AW-1:0] addr;
        logic [WW-1:0] pwdata;
        int unsigned   setup_edge;
    } cfg_t;

    logic        pclock = 1'b0;
    logic        preset = 1'b1;
    int unsigned cyc = 0;
    int unsigned hold_until = 0;
    int          errors = 0;
    int          checks = 0;

    exp_t exp_q[$];
    cfg_t cfg_q[$];
    logic [7:0] model_mem[256];
    logic [7:0] slave_mem[256];

    apb_master_bridge_if #(.PADDR_WIDTH(AW), .PWDATA_WIDTH(WW), .PRDATA_WIDTH(RW)) bus ();

    apb_master_bridge #(
        .PADDR_WIDTH(AW), .PWDATA_WIDTH(WW), .PRDATA_WIDTH(RW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclock (pclock),
        .preset (preset),
        .bus    (bus.master)
    );

    always #5 pclock = ~pclock;
    always @(posedge pclock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference model: one transfer in order, n ACCESS cycles = min(w+1, TO).
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [WW-1:0] d,
                         input int w, input logic err);
        exp_t e;
        cfg_t c;
        int   t;
        int   n;
        logic to;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        t = 0;
        while (!bus.cmd_ready && t < 50) begin
            @(negedge pclock);
            t++;
        end
        if (!bus.cmd_ready) begin
            bound_fail("cmd_accept");
            bus.cmd_valid = 1'b0;
            return;
        end
        to = (w >= TO);
        n  = (w + 1 < TO) ? w + 1 : TO;
        e.timeout  = to;
        e.slverr   = to | err;
        e.rdata    = (!wr && !to) ? model_mem[a[7:0]] : 8'h00;
        e.rsp_edge = cyc + 1 + 1 + n;
        if (wr && !to && !err) model_mem[a[7:0]] = d;
        c.w = w; c.err = err; c.write = wr; c.addr = a;
        c.pwdata = wr ? d : '0;
        c.setup_edge = cyc + 1;
        exp_q.push_back(e);
        cfg_q.push_back(c);
        @(negedge pclock);
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge pclock);
            t++;
        end
        if (exp_q.size() != 0) bound_fail("drain");
    endtask

    // APB slave: pready rises on ACCESS cycle w+1; noise on pready/pslverr/prdata elsewhere.
    initial begin
        cfg_t cur;
        int   k;
        logic active;
        active = 1'b0;
        k = 0;
        bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
        forever begin
            @(negedge pclock);
            bus.pslverr = 1'($urandom);
            bus.prdata  = 8'($urandom);
            bus.pready  = 1'($urandom);
            if (preset) begin
                active = 1'b0;
                bus.pready = 1'b0;
            end else if (bus.psel && !bus.penable) begin
                if (cfg_q.size() == 0) begin
                    bound_fail("unexpected_setup");
                    active = 1'b0;
                end else begin
                    cur = cfg_q.pop_front();
                    active = 1'b1;
                    k = 0;
                    check("setup_edge", 64'(cyc), 64'(cur.setup_edge));
                    check("setup_paddr", 64'(bus.paddr), 64'(cur.addr));
                    check("setup_prwd", 64'(bus.prwd), 64'(cur.write));
                    check("setup_pwdata", 64'(bus.pwdata), 64'(cur.pwdata));
                end
            end else if (bus.psel && bus.penable) begin
                bus.pready = 1'b0;
                if (active) begin
                    k++;
                    check("access_paddr", 64'(bus.paddr), 64'(cur.addr));
                    check("access_prwd", 64'(bus.prwd), 64'(cur.write));
                    check("access_pwdata", 64'(bus.pwdata), 64'(cur.pwdata));
                    if (k > TO) bound_fail("access_too_long");
                    if (k == cur.w + 1) begin
                        bus.pready  = 1'b1;
                        bus.pslverr = cur.err;
                        if (!cur.write) bus.prdata = slave_mem[cur.addr[7:0]];
                        else if (!cur.err) slave_mem[cur.addr[7:0]] = cur.pwdata;
                    end
                end
            end else begin
                active = 1'b0;
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response, checks it is held.
    initial begin
        exp_t          e;
        logic          prev_v;
        logic [RW-1:0] h_rdata;
        logic          h_err;
        logic          h_to;
        prev_v = 1'b0;
        h_rdata = '0; h_err = 1'b0; h_to = 1'b0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge pclock);
            if (preset) begin
                prev_v = 1'b0;
                bus.rsp_ready = 1'b0;
                continue;
            end
            if (bus.rsp_valid) begin
                check("cmd_ready_in_resp", 64'(bus.cmd_ready), 64'd0);
                if (!prev_v) begin
                    if (exp_q.size() == 0) begin
                        bound_fail("unexpected_response");
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                        check("rsp_slverr", 64'(bus.rsp_slverr), 64'(e.slverr));
                        check("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.timeout));
                        check("rsp_latency", 64'(cyc), 64'(e.rsp_edge));
                    end
                    h_rdata = bus.rsp_rdata; h_err = bus.rsp_slverr; h_to = bus.rsp_timeout;
                end else begin
                    check("rsp_hold_rdata", 64'(bus.rsp_rdata), 64'(h_rdata));
                    check("rsp_hold_slverr", 64'(bus.rsp_slverr), 64'(h_err));
                    check("rsp_hold_timeout", 64'(bus.rsp_timeout), 64'(h_to));
                end
            end
            bus.rsp_ready = (cyc < hold_until) ? 1'b0 : ($urandom_range(0, 9) < 7);
            prev_v = bus.rsp_valid && !bus.rsp_ready;
        end
    end

    initial begin
        int w;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 8'(i * 29 + 7);
            slave_mem[i] = 8'(i * 29 + 7);
        end
        model_mem[8'h20] = 8'h3C;
        slave_mem[8'h20] = 8'h3C;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;

        @(negedge pclock);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("rst_rsp_slverr", 64'(bus.rsp_slverr), 64'd0);
        check("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
        check("rst_paddr", 64'(bus.paddr), 64'd0);
        check("rst_prwd", 64'(bus.prwd), 64'd0);
        check("rst_pwdata", 64'(bus.pwdata), 64'd0);
        check("rst_psel", 64'(bus.psel), 64'd0);
        check("rst_penable", 64'(bus.penable), 64'd0);
        preset = 1'b0;
        repeat (2) @(negedge pclock);

        issue(1'b1, 32'h0000_0010, 8'hA5, 0, 1'b0);
        issue(1'b0, 32'h0000_0020, 8'h77, 3, 1'b0);
        issue(1'b1, 32'h0000_0030, 8'h5A, 0, 1'b1);
        issue(1'b0, 32'h0000_0010, 8'h00, 8, 1'b0);
        issue(1'b1, 32'h0000_0040, 8'hC3, 3, 1'b0);
        issue(1'b0, 32'h0000_0040, 8'h11, 0, 1'b0);
        drain();

        hold_until = cyc + 10;
        issue(1'b1, 32'h0000_0050, 8'h96, 0, 1'b0);
        issue(1'b0, 32'h0000_0050, 8'h00, 1, 1'b0);
        drain();

        for (int i = 0; i < 200; i++) begin
            w = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 6));
            issue(1'($urandom), {$urandom}, 8'($urandom), w, ($urandom_range(0, 5) == 0));
            repeat ($urandom_range(0, 2)) @(negedge pclock);
        end
        drain();

        issue(1'b0, 32'h0000_0020, 8'h00, 10, 1'b0);
        @(negedge pclock);
        #2;
        preset = 1'b1;
        exp_q.delete();
        cfg_q.delete();
        #1;
        check("arst_psel", 64'(bus.psel), 64'd0);
        check("arst_penable", 64'(bus.penable), 64'd0);
        check("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("arst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        repeat (2) @(negedge pclock);
        preset = 1'b0;
        repeat (3) @(negedge pclock);
        check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        repeat (10) @(negedge pclock);
        issue(1'b0, 32'h0000_0020, 8'h00, 0, 1'b0);
        drain();
        check("final_queue_empty", 64'(exp_q.size() + cfg_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
